// File: rtl/segmux_scan_if.sv
// Display-side bundle for segmux_scan: digit data/load toward the driver, pins and status back.
// No handshake; load is a one-cycle strobe and every output is registered.
interface segmux_scan_if #(
  parameter int NDIG = 4
);
  logic [4*NDIG-1:0] val;
  logic [NDIG-1:0]   dp;
  logic [NDIG-1:0]   blank;
  logic              load;
  logic [6:0]        seg;
  logic              seg_dp;
  logic [NDIG-1:0]   dig;
  logic              frame;
  logic              pend;

  modport master (
    output val, dp, blank, load,
    input  seg, seg_dp, dig, frame, pend
  );

  modport slave (
    input  val, dp, blank, load,
    output seg, seg_dp, dig, frame, pend
  );
endinterface

// File: rtl/segmux_scan.sv
// Multiplexed NDIG-digit hex 7-segment scanner with frame-synchronous shadow update; SEGMUX_LZB_EN adds leading-zero blanking.
// All pins registered: 1 cycle after cnt/idx/active state; load is always accepted (latest wins), no backpressure.
module segmux_scan #(
  parameter int NDIG        = 4,
  parameter int DIV         = 1000,
  parameter int SEG_ACT_LOW = 0,
  parameter int DIG_ACT_LOW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  segmux_scan_if.slave  bus
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CW = $clog2(DIV);

  // Inactive pin levels; XOR with these converts the active-high view to pin polarity.
  localparam logic [6:0]      SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic            DP_OFF  = (SEG_ACT_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [NDIG-1:0] DIG_OFF = (DIG_ACT_LOW != 0) ? {NDIG{1'b1}} : {NDIG{1'b0}};

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] sh_val_q, sh_val_d, act_val_q, act_val_d;
  logic [NDIG-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [NDIG-1:0]   sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
  logic              pend_q, pend_d;
  logic              frame_q, frame_d;
  logic [6:0]        seg_q, seg_d;
  logic              seg_dp_q, seg_dp_d;
  logic [NDIG-1:0]   dig_q, dig_d;

  logic              slot_end, frame_end;
  logic [3:0]        nib;
  logic              dp_bit, blk_bit;
  logic [NDIG-1:0]   onehot;
  logic [NDIG-1:0]   lzb;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

`ifdef SEGMUX_LZB_EN
  // A digit goes dark while it and everything above it is zero; digit 0 always shows.
  logic zero_run;
  always_comb begin
    zero_run = 1'b1;
    lzb      = '0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      zero_run = zero_run && (act_val_q[4*i +: 4] == 4'h0);
      lzb[i]   = zero_run;
    end
  end
`else
  assign lzb = '0;
`endif

  always_comb begin
    slot_end  = (cnt_q == CW'(DIV - 1));
    frame_end = slot_end && (idx_q == IW'(NDIG - 1));

    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;

    sh_val_d   = sh_val_q;
    sh_dp_d    = sh_dp_q;
    sh_blank_d = sh_blank_q;
    if (bus.load) begin
      sh_val_d   = bus.val;
      sh_dp_d    = bus.dp;
      sh_blank_d = bus.blank;
    end

    // Transfer takes the pre-edge shadow, so a load on the boundary lands next frame.
    act_val_d   = act_val_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    if (frame_end && pend_q) begin
      act_val_d   = sh_val_q;
      act_dp_d    = sh_dp_q;
      act_blank_d = sh_blank_q;
    end

    pend_d = pend_q;
    if (frame_end) pend_d = 1'b0;
    if (bus.load)  pend_d = 1'b1;

    frame_d = frame_end;

    nib     = 4'h0;
    dp_bit  = 1'b0;
    blk_bit = 1'b0;
    onehot  = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == IW'(i)) begin
        nib       = act_val_q[4*i +: 4];
        dp_bit    = act_dp_q[i] & ~act_blank_q[i];
        blk_bit   = act_blank_q[i] | lzb[i];
        onehot[i] = 1'b1;
      end
    end

    if (cnt_q == '0) begin
      seg_d    = SEG_OFF;
      seg_dp_d = DP_OFF;
      dig_d    = DIG_OFF;
    end else begin
      seg_d    = (blk_bit ? 7'h00 : hex7(nib)) ^ SEG_OFF;
      seg_dp_d = dp_bit ^ DP_OFF;
      dig_d    = onehot ^ DIG_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      sh_val_q    <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= '0;
      act_val_q   <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '0;
      pend_q      <= 1'b0;
      frame_q     <= 1'b0;
      seg_q       <= SEG_OFF;
      seg_dp_q    <= DP_OFF;
      dig_q       <= DIG_OFF;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_val_q    <= sh_val_d;
      sh_dp_q     <= sh_dp_d;
      sh_blank_q  <= sh_blank_d;
      act_val_q   <= act_val_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
      pend_q      <= pend_d;
      frame_q     <= frame_d;
      seg_q       <= seg_d;
      seg_dp_q    <= seg_dp_d;
      dig_q       <= dig_d;
    end
  end

  assign bus.seg    = seg_q;
  assign bus.seg_dp = seg_dp_q;
  assign bus.dig    = dig_q;
  assign bus.frame  = frame_q;
  assign bus.pend   = pend_q;

endmodule

// File: tb/tb_segmux_scan.sv
// Directed bench for segmux_scan: NDIG=4, DIV=4, plus an active-low-segment instance for polarity and mid-slot reset.
module tb_segmux_scan;

`ifdef SEGMUX_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst2_n;

  segmux_scan_if #(.NDIG(4)) bus  ();
  segmux_scan_if #(.NDIG(4)) bus2 ();

  segmux_scan #(.NDIG(4), .DIV(4), .SEG_ACT_LOW(0), .DIG_ACT_LOW(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  segmux_scan #(.NDIG(4), .DIV(4), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)) u_dut_al (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] ld_mask;
  logic [15:0] ld_val [16];
  logic [3:0]  ld_dp  [16];
  logic [3:0]  ld_blk [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sched_load(input int at, input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    ld_mask[at] = 1'b1;
    ld_val[at]  = v;
    ld_dp[at]   = d;
    ld_blk[at]  = b;
  endtask

  // One 16-cycle frame starting at digit 0's dead cycle and ending on the frame pulse.
  // segs packs digits {3,2,1,0} at 7 bits each; loads are driven per scheduled sample index.
  task automatic run_frame(input string tag, input logic [27:0] segs, input logic [3:0] dpx,
                           input logic pmid);
    logic [3:0] dexp;
    int k;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      k = i / 4;
      if (i % 4 == 0) begin
        check({tag, " dead seg"}, {25'd0, bus.seg}, 32'h00);
        check({tag, " dead dig"}, {28'd0, bus.dig}, 32'hF);
      end
      if (i % 4 == 2) begin
        dexp = ~(4'b0001 << k);
        check($sformatf("%s d%0d seg", tag, k), {25'd0, bus.seg}, {25'd0, segs[7*k +: 7]});
        check($sformatf("%s d%0d dp", tag, k), {31'd0, bus.seg_dp}, {31'd0, dpx[k]});
        check($sformatf("%s d%0d dig", tag, k), {28'd0, bus.dig}, {28'd0, dexp});
      end
      if (i == 8)  check({tag, " pend mid"}, {31'd0, bus.pend}, {31'd0, pmid});
      if (i == 14) check({tag, " no frame"}, {31'd0, bus.frame}, 32'd0);
      if (i == 15) check({tag, " frame"}, {31'd0, bus.frame}, 32'd1);
      bus.load  = ld_mask[i];
      bus.val   = ld_val[i];
      bus.dp    = ld_dp[i];
      bus.blank = ld_blk[i];
    end
    ld_mask = '0;
  endtask

  initial begin
    logic [3:0] dig_seq [16];
    int t;
    dig_seq = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
    ld_mask = '0;
    for (int i = 0; i < 16; i++) begin
      ld_val[i] = '0;
      ld_dp[i]  = '0;
      ld_blk[i] = '0;
    end
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    bus.val = '0;  bus.dp = '0;  bus.blank = '0;  bus.load = 1'b0;
    bus2.val = '0; bus2.dp = '0; bus2.blank = '0; bus2.load = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst seg", {25'd0, bus.seg}, 32'h00);
    check("rst dp", {31'd0, bus.seg_dp}, 32'd0);
    check("rst dig", {28'd0, bus.dig}, 32'hF);
    check("rst pend", {31'd0, bus.pend}, 32'd0);
    check("rst frame", {31'd0, bus.frame}, 32'd0);
    rst_n = 1'b1;

    // First frame: dig scan order against the hand table, active registers all zero
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("t1 dig[%0d]", i), {28'd0, bus.dig}, {28'd0, dig_seq[i]});
      check($sformatf("t1 seg[%0d]", i), {25'd0, bus.seg}, (i % 4 == 0) ? 32'h00 : 32'h3F);
      check($sformatf("t1 frame[%0d]", i), {31'd0, bus.frame}, (i == 15) ? 32'd1 : 32'd0);
      if (i < 3) check($sformatf("t1 pend[%0d]", i), {31'd0, bus.pend}, 32'd0);
    end

    // Load B5A0 right after the pulse; shown only after the following frame pulse
    bus.load = 1'b1; bus.val = 16'hB5A0; bus.dp = 4'b0100; bus.blank = 4'b0000;
    run_frame("t2 old", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000, 1'b1);
    check("t2 pend clr", {31'd0, bus.pend}, 32'd0);

    // Two loads in one frame: only the later one reaches the display
    sched_load(2, 16'h1234, 4'b0000, 4'b0000);
    sched_load(6, 16'h5678, 4'b0000, 4'b0000);
    run_frame("t2 new", {7'h7C, 7'h6D, 7'h77, 7'h3F}, 4'b0100, 1'b1);
    check("t3 pend clr", {31'd0, bus.pend}, 32'd0);

    // Load on the boundary cycle itself: earlier shadow transfers, boundary value waits a frame
    sched_load(5, 16'h9C0D, 4'b0000, 4'b0000);
    sched_load(14, 16'hEF21, 4'b1011, 4'b0010);
    run_frame("t3 5678", {7'h6D, 7'h7D, 7'h07, 7'h7F}, 4'b0000, 1'b1);
    check("t4 pend held", {31'd0, bus.pend}, 32'd1);
    run_frame("t4 old", {7'h6F, 7'h39, 7'h3F, 7'h5E}, 4'b0000, 1'b1);
    check("t4 pend clr", {31'd0, bus.pend}, 32'd0);

    // Boundary value with blank on digit 1 (its dp request is suppressed)
    sched_load(3, 16'h0070, 4'b0000, 4'b0000);
    run_frame("t4 new", {7'h79, 7'h71, 7'h00, 7'h06}, 4'b1001, 1'b1);

    // Leading zeros: dark only with the macro; dp of an auto-blanked digit still lit
    sched_load(3, 16'h0403, 4'b1100, 4'b0000);
    run_frame("t5 0070", {LZB ? 7'h00 : 7'h3F, LZB ? 7'h00 : 7'h3F, 7'h07, 7'h3F}, 4'b0000, 1'b1);
    run_frame("t5 0403", {LZB ? 7'h00 : 7'h3F, 7'h66, 7'h3F, 7'h4F}, 4'b1100, 1'b0);

    // Active-low segment instance
    @(negedge clk);
    check("t6 rst seg", {25'd0, bus2.seg}, 32'h7F);
    check("t6 rst dp", {31'd0, bus2.seg_dp}, 32'd1);
    check("t6 rst dig", {28'd0, bus2.dig}, 32'hF);
    rst2_n = 1'b1;
    bus2.load = 1'b1; bus2.val = 16'h0008; bus2.dp = 4'b0000; bus2.blank = 4'b0000;
    @(negedge clk);
    bus2.load = 1'b0;
    t = 0;
    while (bus2.frame !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("t6 frame seen", {31'd0, bus2.frame}, 32'd1);
    check("t6 pend clr", {31'd0, bus2.pend}, 32'd0);
    @(negedge clk);
    check("t6 dead seg", {25'd0, bus2.seg}, 32'h7F);
    check("t6 dead dig", {28'd0, bus2.dig}, 32'hF);
    @(negedge clk);
    check("t6 d0 seg", {25'd0, bus2.seg}, 32'h00);
    check("t6 d0 dp", {31'd0, bus2.seg_dp}, 32'd1);
    check("t6 d0 dig", {28'd0, bus2.dig}, 32'hE);

    // Reset mid-slot
    rst2_n = 1'b0;
    @(negedge clk);
    check("t6 mrst seg", {25'd0, bus2.seg}, 32'h7F);
    check("t6 mrst dp", {31'd0, bus2.seg_dp}, 32'd1);
    check("t6 mrst dig", {28'd0, bus2.dig}, 32'hF);
    check("t6 mrst frame", {31'd0, bus2.frame}, 32'd0);
    rst2_n = 1'b1;
    @(negedge clk);
    check("t6 re dead dig", {28'd0, bus2.dig}, 32'hF);
    @(negedge clk);
    check("t6 re idx0 dig", {28'd0, bus2.dig}, 32'hE);
    check("t6 re idx0 seg", {25'd0, bus2.seg}, 32'h40);
    check("t6 re pend", {31'd0, bus2.pend}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
